hilo_divider: RTL and testbench

- Multicycle integer divide unit for the EX stage. Responds to div/divu issued by the ALU decode path and owns the HI/LO architectural registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Raises a stall request while a read or write would observe a division still in flight.
- Radix-2 restoring algorithm, one quotient bit per clock.

---
 rtl/hilo_divider.sv | 194 +++++++++++++++++++
 tb/tb_hilo_divider.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_divider.sv
// hilo_divider: multicycle radix-2 restoring divider that owns the HI/LO
// registers. It produces one quotient bit per clock, applies the result
// signs in a final fix-up cycle, and serves mfhi/mflo/mthi/mtlo traffic.
//
// Ports
//   Clock           rising-edge clock
//   Reset           synchronous, active-low
//   Start/Signed    issue div (Signed=1) or divu; sampled only when idle
//   A, B            dividend / divisor, sampled with Start
//   ReadHiLo        mfhi/mflo in EX this cycle
//   WriteHi/WriteLo mthi/mtlo strobes, WData is the write data
//   Hi, Lo          remainder / quotient registers
//   Busy            division in flight
//   Done            one-cycle pulse after Hi/Lo are updated by a division
//   DivZero         sticky flag: the last division had B=0
//   Stall           Busy & (ReadHiLo | WriteHi | WriteLo)
//
// Optional build macro DIV_EARLY_OUT_EN: when |B| > |A| the divide skips
// the iteration phase (quotient 0, remainder A). Results are identical.
//
// state | meaning
// IDLE  | accept Start and mthi/mtlo writes
// RUN   | WIDTH shift/subtract iterations
// FIX   | apply signs, write Hi/Lo, raise Done next cycle
module hilo_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             ReadHiLo,
   input  logic             WriteHi,
   input  logic             WriteLo,
   input  logic [WIDTH-1:0] WData,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic             Stall
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH:0]     div_q, div_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   // Magnitudes are WIDTH+1 bits so that -2^(WIDTH-1) has a representable
   // absolute value.
   logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
   logic               b_zero, early_out;
   logic [WIDTH+1:0]   shifted;
   logic               no_borrow;
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign a_ext  = {Signed & A[WIDTH-1], A};
   assign b_ext  = {Signed & B[WIDTH-1], B};
   assign a_mag  = a_ext[WIDTH] ? -a_ext : a_ext;
   assign b_mag  = b_ext[WIDTH] ? -b_ext : b_ext;
   assign b_zero = (B == '0);

`ifdef DIV_EARLY_OUT_EN
   assign early_out = (b_mag > a_mag);
`else
   assign early_out = 1'b0;
`endif

   assign shifted   = {rem_q, quo_q[WIDTH-1]};
   assign no_borrow = (shifted >= {1'b0, div_q});
   assign q_fix     = qneg_q ? -quo_q : quo_q;
   assign r_fix     = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

   // state and datapath registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         zero_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         zero_q  <= zero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (Start) state_d = (b_zero | early_out) ? S_FIX : S_RUN;
         S_RUN:   if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // datapath next values
   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      zero_d = zero_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      dz_d   = dz_q;
      unique case (state_q)
         S_IDLE: begin
            if (WriteHi) hi_d = WData;
            if (WriteLo) lo_d = WData;
            if (Start) begin
               div_d  = b_mag;
               qneg_d = (A[WIDTH-1] ^ B[WIDTH-1]) & Signed;
               rneg_d = A[WIDTH-1] & Signed;
               zero_d = b_zero;
               cnt_d  = CNT_W'(WIDTH);
               dz_d   = 1'b0;
               // Skipping the iterations: the remainder is |A| and the
               // sign fix-up in FIX turns it back into A.
               if (b_zero | early_out) begin
                  rem_d = a_mag;
                  quo_d = '0;
               end else begin
                  rem_d = '0;
                  quo_d = a_mag[WIDTH-1:0];
               end
            end
         end
         S_RUN: begin
            rem_d = no_borrow ? (WIDTH+1)'(shifted - {1'b0, div_q})
                              : shifted[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], no_borrow};
            cnt_d = cnt_q - CNT_W'(1);
         end
         S_FIX: begin
            done_d = 1'b1;
            hi_d   = r_fix;
            if (zero_q) begin
               lo_d = '1;
               dz_d = 1'b1;
            end else begin
               lo_d = q_fix;
            end
         end
         default: ;
      endcase
   end

   // outputs
   always_comb begin
      Busy    = (state_q != S_IDLE);
      Stall   = Busy & (ReadHiLo | WriteHi | WriteLo);
      Hi      = hi_q;
      Lo      = lo_q;
      Done    = done_q;
      DivZero = dz_q;
   end

endmodule

// File: tb/tb_hilo_divider.sv
module tb_hilo_divider;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic        Signed = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        ReadHiLo = 1'b0;
   logic        WriteHi = 1'b0;
   logic        WriteLo = 1'b0;
   logic [31:0] WData = '0;
   logic [31:0] Hi, Lo;
   logic        Busy, Done, DivZero, Stall;

   hilo_divider #(.WIDTH(32), .CNT_W(6)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed),
      .A(A), .B(B), .ReadHiLo(ReadHiLo), .WriteHi(WriteHi),
      .WriteLo(WriteLo), .WData(WData), .Hi(Hi), .Lo(Lo), .Busy(Busy),
      .Done(Done), .DivZero(DivZero), .Stall(Stall)
   );

   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Reference: plain integer division, truncating toward zero, remainder
   // takes the dividend's sign. Latency in busy cycles.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, output logic [31:0] lo,
                                 output logic [31:0] hi, output int lat);
      longint sa, sb, q, r;
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      if (sb == 0) begin
         lo  = 32'hFFFF_FFFF;
         hi  = a;
         lat = 1;
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         lo  = q[31:0];
         hi  = r[31:0];
         lat = 33;
`ifdef DIV_EARLY_OUT_EN
         begin
            longint ma, mb;
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            if (mb > ma) lat = 1;
         end
`endif
      end
   endfunction

   // One full division with optional mfhi/mflo held high, mthi during
   // busy, and a stray Start poked in mid-division.
   task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input logic exp_dz,
                         input logic rd, input logic wh, input logic sb);
      logic [31:0] mlo, mhi;
      int lat, cycles, stall_bad, done_bad;
      model(a, b, s, mlo, mhi, lat);
      Start = 1'b1; Signed = s; A = a; B = b; ReadHiLo = rd;
      step();
      Start = 1'b0; A = $urandom; B = $urandom; Signed = ~s;
      WriteHi = wh; WData = 32'hDEAD_BEEF;
      #1;
      chk1({nm, " dz_clear"}, DivZero, 1'b0);
      cycles = 0; stall_bad = 0; done_bad = 0;
      while (Busy === 1'b1 && cycles < 200) begin
         cycles++;
         if (Stall !== (rd | wh)) stall_bad++;
         if (Done !== 1'b0) done_bad++;
         if (cycles == 5 && sb) begin
            Start = 1'b1; A = 32'd1; B = 32'd1;
         end else begin
            Start = 1'b0;
         end
         step();
      end
      Start = 1'b0; WriteHi = 1'b0;
      #1;
      chk({nm, " latency"}, 32'(cycles), 32'(lat));
      chk({nm, " stall_busy"}, 32'(stall_bad), 32'd0);
      chk({nm, " done_early"}, 32'(done_bad), 32'd0);
      chk1({nm, " done"}, Done, 1'b1);
      chk1({nm, " stall_done"}, Stall, 1'b0);
      chk({nm, " lo"}, Lo, exp_lo);
      chk({nm, " hi"}, Hi, exp_hi);
      chk1({nm, " divzero"}, DivZero, exp_dz);
      ReadHiLo = 1'b0;
      step();
      chk1({nm, " done_pulse"}, Done, 1'b0);
   endtask

   initial begin
      logic [31:0] ra, rb, elo, ehi;
      logic        rs;
      int          lat, k, bad;

      tbl[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
      tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      tbl[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'h0,          1'b0};
      tbl[3] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
      tbl[4] = '{32'd50,         32'd5,          1'b0, 32'd10,         32'd0,          1'b0};
      tbl[5] = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          1'b0};

      // reset state
      Reset = 1'b0;
      Start = 1'b1; A = 32'd9; B = 32'd3; WriteHi = 1'b1; WData = 32'h1111_1111;
      step(); step();
      chk1("rst busy", Busy, 1'b0);
      chk1("rst done", Done, 1'b0);
      chk1("rst divzero", DivZero, 1'b0);
      chk("rst hi", Hi, 32'h0);
      chk("rst lo", Lo, 32'h0);
      Start = 1'b0; WriteHi = 1'b0;
      #1;
      chk1("rst stall", Stall, 1'b0);
      Reset = 1'b1;
      step();

      for (int i = 0; i < 6; i++)
         do_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s,
                tbl[i].lo, tbl[i].hi, tbl[i].dz, 1'b0, 1'b0, 1'b0);

      // mfhi held, mthi dropped while busy, stray Start ignored
      do_div("rd_wh", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1);

      // idle writes; read while idle never stalls
      ReadHiLo = 1'b1; WriteHi = 1'b1; WData = 32'hAAAA_0001;
      #1;
      chk1("idle stall", Stall, 1'b0);
      step();
      WriteHi = 1'b0; WriteLo = 1'b1; WData = 32'hBBBB_0002;
      step();
      WriteLo = 1'b0; ReadHiLo = 1'b0;
      chk("mthi idle", Hi, 32'hAAAA_0001);
      chk("mtlo idle", Lo, 32'hBBBB_0002);

      // mtlo together with Start lands, then FIX overwrites it
      WriteLo = 1'b1; WData = 32'h5555_5555;
      Start = 1'b1; Signed = 1'b0; A = 32'd100; B = 32'd7;
      step();
      WriteLo = 1'b0; Start = 1'b0;
      chk("mtlo with start", Lo, 32'h5555_5555);
      k = 0;
      while (Busy === 1'b1 && k < 200) begin k++; step(); end
      chk1("wr_start done", Done, 1'b1);
      chk("wr_start lo", Lo, 32'd14);
      chk("wr_start hi", Hi, 32'd2);
      step();

      // reset mid-division aborts it
      Start = 1'b1; Signed = 1'b0; A = 32'd50; B = 32'd5;
      step();
      Start = 1'b0;
      repeat (10) step();
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      chk1("abort busy", Busy, 1'b0);
      chk1("abort done", Done, 1'b0);
      chk("abort hi", Hi, 32'h0);
      chk("abort lo", Lo, 32'h0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (Done !== 1'b0 || Busy !== 1'b0) bad++;
         step();
      end
      chk("abort quiet", 32'(bad), 32'd0);
      do_div("fresh", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // randomized against the reference model
      for (int i = 0; i < 40; i++) begin
         k  = $urandom_range(0, 9);
         ra = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
         if (k == 0)      rb = 32'd0;
         else if (k < 4)  rb = 32'($urandom_range(1, 20));
         else if (k < 6)  rb = -32'($urandom_range(1, 20));
         else             rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         model(ra, rb, rs, elo, ehi, lat);
         do_div($sformatf("rnd%0d", i), ra, rb, rs, elo, ehi, (rb == 32'd0),
                1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
